// File: rtl/multicycle_ctrl_fsm.sv
`timescale 1ns/1ps
// Multi-cycle sequencer: FETCH/DECODE/EXEC/MEM/WB control for the 3-bit-opcode datapath.
// Latency: add/addi/sll 4 cycles, lw 5, sw 4 with zero-wait memories; +1 per memory wait cycle.
// Backpressure: stalls in FETCH/MEM until imem_ready/dmem_ready; MEM_TIMEOUT cycles without ready -> sticky ERROR.
//
// Ports: clk/reset_n (async active-low), run (fetch enable), opcode (IR opcode, captured in DECODE),
//        imem_ready/dmem_ready (one-cycle memory acks), memory requests (imem_req, dmem_req, dmem_we),
//        datapath strobes/selects (pc_write, ir_write, reg_write, mem_to_reg, alu_src, reg_dst, alu_op),
//        status (busy, err, retired).
module multicycle_ctrl_fsm #(
  parameter int CNT_W       = 16,
  parameter int MEM_TIMEOUT = 15
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             run,
  input  logic [2:0]       opcode,
  input  logic             imem_ready,
  input  logic             dmem_ready,
  output logic             imem_req,
  output logic             dmem_req,
  output logic             dmem_we,
  output logic             pc_write,
  output logic             ir_write,
  output logic             reg_write,
  output logic             mem_to_reg,
  output logic             alu_src,
  output logic             reg_dst,
  output logic [2:0]       alu_op,
  output logic             busy,
  output logic             err,
  output logic [CNT_W-1:0] retired
);

  localparam logic [2:0]       OP_ADD    = 3'b000;
  localparam logic [2:0]       OP_SW     = 3'b101;
  localparam logic [2:0]       OP_LW     = 3'b110;
  localparam logic [2:0]       OP_SLL    = 3'b111;
  localparam logic [7:0]       WAIT_LAST = 8'(MEM_TIMEOUT - 1);
  localparam logic [CNT_W-1:0] RET_ONE   = CNT_W'(1);

  typedef enum logic [2:0] {
    S_IDLE, S_FETCH, S_DECODE, S_EXEC, S_MEM, S_WB, S_ERROR
  } state_t;

  state_t     state, state_n;
  logic [2:0] op_q, op_n;
  logic [7:0] wait_cnt;
  logic       retire;
  logic       wait_state;
  logic       ready_now;
  logic       timeout;
  logic       alu_phase_n;

  // Only the ready belonging to the current wait state counts.
  assign wait_state = (state == S_FETCH) || (state == S_MEM);
  assign ready_now  = (state == S_FETCH) ? imem_ready : dmem_ready;
  // A ready in the final allowed cycle wins over the timeout.
  assign timeout    = wait_state && !ready_now && (wait_cnt == WAIT_LAST);

  always_comb begin
    state_n = state;
    op_n    = op_q;
    retire  = 1'b0;
    case (state)
      S_IDLE:   if (run) state_n = S_FETCH;
      S_FETCH: begin
        if (imem_ready)   state_n = S_DECODE;
        else if (timeout) state_n = S_ERROR;
      end
      S_DECODE: begin
        op_n    = opcode;
        state_n = S_EXEC;
      end
      S_EXEC:   state_n = ((op_q == OP_SW) || (op_q == OP_LW)) ? S_MEM : S_WB;
      S_MEM: begin
        if (dmem_ready) begin
          if (op_q == OP_SW) begin
            retire  = 1'b1;
            state_n = run ? S_FETCH : S_IDLE;
          end else begin
            state_n = S_WB;
          end
        end else if (timeout) begin
          state_n = S_ERROR;
        end
      end
      S_WB: begin
        retire  = 1'b1;
        state_n = run ? S_FETCH : S_IDLE;
      end
      S_ERROR:  state_n = S_ERROR;
      default:  state_n = S_IDLE;
    endcase
  end

  assign alu_phase_n = (state_n == S_EXEC) || (state_n == S_MEM) || (state_n == S_WB);

  // Outputs are registered from the next state so strobes come straight off flops.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state      <= S_IDLE;
      op_q       <= '0;
      wait_cnt   <= '0;
      retired    <= '0;
      imem_req   <= 1'b0;
      dmem_req   <= 1'b0;
      dmem_we    <= 1'b0;
      reg_write  <= 1'b0;
      mem_to_reg <= 1'b0;
      alu_src    <= 1'b0;
      reg_dst    <= 1'b0;
      busy       <= 1'b0;
      err        <= 1'b0;
    end else begin
      state <= state_n;
      op_q  <= op_n;
      // Every state change clears the counter, so each FETCH/MEM visit starts from zero.
      if (state_n != state) wait_cnt <= '0;
      else if (wait_state)  wait_cnt <= wait_cnt + 8'd1;
      if (retire) retired <= retired + RET_ONE;
      imem_req   <= (state_n == S_FETCH);
      dmem_req   <= (state_n == S_MEM);
      dmem_we    <= (state_n == S_MEM) && (op_n == OP_SW);
      reg_write  <= (state_n == S_WB);
      mem_to_reg <= (state_n == S_WB) && (op_n == OP_LW);
      alu_src    <= alu_phase_n && (op_n == OP_ADD);
      reg_dst    <= alu_phase_n && ((op_n == OP_ADD) || (op_n == OP_SLL));
      busy       <= (state_n != S_IDLE) && (state_n != S_ERROR);
      err        <= (state_n == S_ERROR);
    end
  end

  // IR/PC load in the cycle the fetch is acknowledged; imem_req is low outside FETCH.
  assign ir_write = imem_req & imem_ready;
  assign pc_write = imem_req & imem_ready;
  assign alu_op   = op_q;

endmodule

// File: tb/tb_multicycle_ctrl_fsm.sv
`timescale 1ns/1ps
// Bench for multicycle_ctrl_fsm: expected per-cycle traces are expanded from instruction
// transactions (opcode, fetch waits, data waits, run-after) into a vector table, then applied.
// Runs with CNT_W=2, MEM_TIMEOUT=3 so counter wrap and timeouts are reachable quickly.
module tb_multicycle_ctrl_fsm;
  localparam int CNT_W = 2;
  localparam int TMO   = 3;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic             reset_n, run, imem_ready, dmem_ready;
  logic [2:0]       opcode;
  logic             imem_req, dmem_req, dmem_we, pc_write, ir_write, reg_write;
  logic             mem_to_reg, alu_src, reg_dst, busy, err;
  logic [2:0]       alu_op;
  logic [CNT_W-1:0] retired;

  multicycle_ctrl_fsm #(.CNT_W(CNT_W), .MEM_TIMEOUT(TMO)) dut (
    .clk(clk), .reset_n(reset_n), .run(run), .opcode(opcode),
    .imem_ready(imem_ready), .dmem_ready(dmem_ready),
    .imem_req(imem_req), .dmem_req(dmem_req), .dmem_we(dmem_we),
    .pc_write(pc_write), .ir_write(ir_write), .reg_write(reg_write),
    .mem_to_reg(mem_to_reg), .alu_src(alu_src), .reg_dst(reg_dst),
    .alu_op(alu_op), .busy(busy), .err(err), .retired(retired)
  );

  logic [10:0] act_o;
  assign act_o = {imem_req, dmem_req, dmem_we, pc_write, ir_write, reg_write,
                  mem_to_reg, alu_src, reg_dst, busy, err};

  typedef struct {
    logic             r;
    logic [2:0]       opc;
    logic             ir;
    logic             dr;
    logic [10:0]      eo;
    logic             ca;
    logic [2:0]       ealu;
    logic [CNT_W-1:0] eret;
  } vec_t;

  vec_t             tbl[$];
  int               total = 0;
  int               bad   = 0;
  logic [CNT_W-1:0] exp_ret = '0;

  function automatic logic [10:0] mk(input logic imr, input logic dmr, input logic we,
                                     input logic irw, input logic rw, input logic m2r,
                                     input logic as, input logic rd, input logic bz,
                                     input logic er);
    return {imr, dmr, we, irw, irw, rw, m2r, as, rd, bz, er};
  endfunction

  function automatic logic rb();
    return 1'($urandom_range(0, 1));
  endfunction

  function automatic logic [2:0] rop();
    return 3'($urandom_range(0, 7));
  endfunction

  task automatic chk(input string nm, input int idx, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s[%0d] got %h want %h", nm, idx, act, exp);
    end
  endtask

  task automatic push(input logic r, input logic [2:0] o, input logic ir_i, input logic dr_i,
                      input logic [10:0] eo, input logic ca, input logic [2:0] ealu);
    vec_t v;
    v.r = r; v.opc = o; v.ir = ir_i; v.dr = dr_i;
    v.eo = eo; v.ca = ca; v.ealu = ealu; v.eret = exp_ret;
    tbl.push_back(v);
  endtask

  // n idle cycles; run is low except possibly the last one (go=1 starts a fetch).
  task automatic add_idle(input int n, input logic go);
    for (int i = 0; i < n; i++)
      push((i == n - 1) ? go : 1'b0, rop(), rb(), rb(), mk(0,0,0,0,0,0,0,0,0,0), 1'b0, 3'd0);
  endtask

  // One instruction: wi fetch wait cycles, wd data wait cycles, go = run at retirement.
  // Inputs the controller must ignore in a given cycle are randomized.
  task automatic add_instr(input logic [2:0] op, input int wi, input int wd, input logic go);
    logic is_lw, is_sw, as, rd;
    is_lw = (op == 3'b110);
    is_sw = (op == 3'b101);
    as    = (op == 3'b000);
    rd    = (op == 3'b000) || (op == 3'b111);
    for (int i = 0; i < wi; i++)
      push(rb(), rop(), 1'b0, rb(), mk(1,0,0,0,0,0,0,0,1,0), 1'b0, 3'd0);
    push(rb(), rop(), 1'b1, rb(), mk(1,0,0,1,0,0,0,0,1,0), 1'b0, 3'd0);
    push(rb(), op, rb(), rb(), mk(0,0,0,0,0,0,0,0,1,0), 1'b0, 3'd0);
    push(rb(), rop(), rb(), rb(), mk(0,0,0,0,0,0,as,rd,1,0), 1'b1, op);
    if (is_lw || is_sw) begin
      for (int i = 0; i < wd; i++)
        push(rb(), rop(), rb(), 1'b0, mk(0,1,is_sw,0,0,0,as,rd,1,0), 1'b1, op);
      push(is_sw ? go : rb(), rop(), rb(), 1'b1, mk(0,1,is_sw,0,0,0,as,rd,1,0), 1'b1, op);
    end
    if (!is_sw)
      push(go, rop(), rb(), rb(), mk(0,0,0,0,1,is_lw,as,rd,1,0), 1'b1, op);
    exp_ret = CNT_W'(exp_ret + 1);
  endtask

  // Entry/exit point: #1 after a rising edge.
  task automatic apply_table(input string nm);
    for (int i = 0; i < tbl.size(); i++) begin
      run = tbl[i].r; opcode = tbl[i].opc;
      imem_ready = tbl[i].ir; dmem_ready = tbl[i].dr;
      @(negedge clk);
      chk({nm, "_out"}, i, 32'(act_o), 32'(tbl[i].eo));
      chk({nm, "_ret"}, i, 32'(retired), 32'(tbl[i].eret));
      if (tbl[i].ca) chk({nm, "_aluop"}, i, 32'(alu_op), 32'(tbl[i].ealu));
      @(posedge clk); #1;
    end
    tbl.delete();
  endtask

  task automatic hcheck(input string nm, input logic [10:0] eo);
    @(negedge clk);
    chk(nm, 0, 32'(act_o), 32'(eo));
    @(posedge clk); #1;
  endtask

  task automatic do_reset();
    reset_n = 1'b0; run = 1'b0; opcode = '0; imem_ready = 1'b0; dmem_ready = 1'b0;
    @(negedge clk);
    chk("rst_out", 0, 32'(act_o), 32'd0);
    chk("rst_ret", 0, 32'(retired), 32'd0);
    chk("rst_aluop", 0, 32'(alu_op), 32'd0);
    @(negedge clk);
    reset_n = 1'b1;
    exp_ret = '0;
    @(posedge clk); #1;
  endtask

  initial begin
    do_reset();

    // Directed: add, lw with 2 data waits, sw, then addi-class ops wrapping the counter.
    add_idle(2, 1'b1);
    add_instr(3'b000, 0, 0, 1'b1);
    add_instr(3'b110, 0, 2, 1'b1);
    add_instr(3'b101, 0, 0, 1'b1);
    add_instr(3'b011, 0, 0, 1'b1);
    add_instr(3'b011, 2, 0, 1'b1);
    add_instr(3'b001, 0, 0, 1'b0);
    add_idle(2, 1'b1);
    add_instr(3'b111, 1, 0, 1'b1);
    add_instr(3'b101, 1, 2, 1'b0);
    add_idle(1, 1'b0);
    apply_table("dir");

    // Fetch timeout: three unanswered FETCH cycles, then sticky ERROR.
    do_reset();
    run = 1'b1;
    hcheck("fto_idle", mk(0,0,0,0,0,0,0,0,0,0));
    run = 1'b0;
    for (int i = 0; i < TMO; i++) hcheck("fto_fetch", mk(1,0,0,0,0,0,0,0,1,0));
    imem_ready = 1'b1; run = 1'b1;
    hcheck("fto_err", mk(0,0,0,0,0,0,0,0,0,1));
    imem_ready = 1'b0;
    hcheck("fto_err_hold", mk(0,0,0,0,0,0,0,0,0,1));

    // Data timeout on a lw.
    do_reset();
    add_idle(1, 1'b1);
    push(1'b0, 3'd0, 1'b1, 1'b0, mk(1,0,0,1,0,0,0,0,1,0), 1'b0, 3'd0);
    push(1'b0, 3'b110, 1'b0, 1'b0, mk(0,0,0,0,0,0,0,0,1,0), 1'b0, 3'd0);
    push(1'b0, 3'd0, 1'b0, 1'b0, mk(0,0,0,0,0,0,0,0,1,0), 1'b1, 3'b110);
    for (int i = 0; i < TMO; i++)
      push(1'b1, 3'd0, 1'b0, 1'b0, mk(0,1,0,0,0,0,0,0,1,0), 1'b1, 3'b110);
    push(1'b1, 3'd0, 1'b0, 1'b1, mk(0,0,0,0,0,0,0,0,0,1), 1'b0, 3'd0);
    push(1'b1, 3'd0, 1'b1, 1'b0, mk(0,0,0,0,0,0,0,0,0,1), 1'b0, 3'd0);
    apply_table("dto");

    // Reset asserted mid-MEM of a lw after one retirement.
    do_reset();
    add_idle(1, 1'b1);
    add_instr(3'b011, 0, 0, 1'b1);
    push(1'b1, 3'd0, 1'b1, 1'b0, mk(1,0,0,1,0,0,0,0,1,0), 1'b0, 3'd0);
    push(1'b1, 3'b110, 1'b0, 1'b0, mk(0,0,0,0,0,0,0,0,1,0), 1'b0, 3'd0);
    push(1'b1, 3'd0, 1'b0, 1'b0, mk(0,0,0,0,0,0,0,0,1,0), 1'b1, 3'b110);
    push(1'b1, 3'd0, 1'b0, 1'b0, mk(0,1,0,0,0,0,0,0,1,0), 1'b1, 3'b110);
    apply_table("mrst");
    #1;
    chk("mrst_req_before", 0, 32'(dmem_req), 32'd1);
    reset_n = 1'b0;
    #1;
    chk("mrst_async_out", 0, 32'(act_o), 32'd0);
    chk("mrst_async_ret", 0, 32'(retired), 32'd0);
    do_reset();
    add_idle(1, 1'b1);
    add_instr(3'b000, 0, 0, 1'b0);
    add_idle(1, 1'b0);
    apply_table("restart");

    // Random instruction stream.
    for (int k = 0; k < 40; k++) begin
      logic go;
      go = (k == 39) ? 1'b0 : rb();
      if (k == 0) add_idle(1, 1'b1);
      add_instr(rop(), $urandom_range(0, TMO - 1), $urandom_range(0, TMO - 1), go);
      if (!go) add_idle($urandom_range(1, 3), (k != 39));
    end
    apply_table("rnd");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
